serial_add_ctrl: RTL and testbench

Sequencer that feeds a bit-serial N-bit adder datapath. Bit-serial adder = combinational full-adder bit plus carry flop.
- Upstream side: accepts parallel operands over a valid/ready handshake.
- Serial side: presents operands LSB-first, one bit per clock, with a carry-clear strobe on the first bit.
- Downstream side: collects the returned sum bits and final carry into a parallel result, offered over a valid/ready handshake.
Sits directly upstream and downstream of the serial adder bit-slice; the adder itself is not inside this block.

---
 rtl/serial_add_ctrl_pkg.sv | 17 +
 rtl/serial_add_ctrl_if.sv | 35 +++
 rtl/serial_add_ctrl_ser_shift_reg.sv | 23 ++
 rtl/serial_add_ctrl.sv | 103 ++++++++++
 tb/tb_serial_add_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and sizing helpers for the serial adder sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int unsigned DEFAULT_N = 4;

  // Bit-counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand, serial and result signals between the sequencer and its neighbours.
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) ();

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ser_en;
  logic         ser_first;
  logic         ser_a;
  logic         ser_b;
  logic         ser_sum;
  logic         ser_cout;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;

  // Environment side: producer of operands, serial adder, result consumer.
  modport master (
    output in_valid, a, b, ser_sum, ser_cout, out_ready,
    input  in_ready, ser_en, ser_first, ser_a, ser_b, out_valid, sum, cout
  );

  // Sequencer side.
  modport slave (
    input  in_valid, a, b, ser_sum, ser_cout, out_ready,
    output in_ready, ser_en, ser_first, ser_a, ser_b, out_valid, sum, cout
  );

endinterface

// File: rtl/serial_add_ctrl_ser_shift_reg.sv
// N-bit right-shift register: sync load, shift enable, serial in at the MSB.
module ser_shift_reg
  import serial_add_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         shift,
  input  logic         ser_in,
  output logic [N-1:0] q
);

  // Load has priority over shift; reset clears the register.
  always_ff @(posedge clk) begin
    if (rst)        q <= '0;
    else if (load)  q <= load_val;
    else if (shift) q <= {ser_in, q[N-1:1]};
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencer around an external bit-serial adder: parallel in, LSB-first serial
// out, serial sum back in, parallel registered result out.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned N  = DEFAULT_N,
  parameter int unsigned CW = cnt_width(N)
) (
  input logic              clk,
  input logic              rst,
  serial_add_ctrl_if.slave bus
);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  sum_q;
  logic          accept;
  logic          shifting;
  logic          last;
  logic          unused_bits;

  assign accept   = (state == IDLE) && bus.in_valid;
  assign shifting = (state == SHIFT);
  assign last     = shifting && (cnt == CW'(N - 1));

  // Only the operand LSBs and the upper sum bits feed logic.
  assign unused_bits = ^{a_q[N-1:1], b_q[N-1:1], sum_q[0]};

  ser_shift_reg #(.N(N)) u_a_sh (
    .clk(clk), .rst(rst), .load(accept), .load_val(bus.a),
    .shift(shifting), .ser_in(1'b0), .q(a_q)
  );

  ser_shift_reg #(.N(N)) u_b_sh (
    .clk(clk), .rst(rst), .load(accept), .load_val(bus.b),
    .shift(shifting), .ser_in(1'b0), .q(b_q)
  );

  ser_shift_reg #(.N(N)) u_sum_sh (
    .clk(clk), .rst(rst), .load(accept), .load_val('0),
    .shift(shifting), .ser_in(bus.ser_sum), .q(sum_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_nxt = SHIFT;
      SHIFT:   if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bit counter: cleared on accept, holds at N-1 after the last bit so it never wraps.
  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (accept)           cnt <= '0;
    else if (shifting && !last) cnt <= cnt + 1'b1;
  end

  // Capture the result, including the final sum bit still on the serial input.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sum  <= '0;
      bus.cout <= 1'b0;
    end else if (last) begin
      bus.sum  <= {bus.ser_sum, sum_q[N-1:1]};
      bus.cout <= bus.ser_cout;
    end
  end

  // State-decoded handshake and serial outputs.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.ser_en    = 1'b0;
    bus.ser_first = 1'b0;
    bus.ser_a     = 1'b0;
    bus.ser_b     = 1'b0;
    unique case (state)
      IDLE:  bus.in_ready = 1'b1;
      SHIFT: begin
        bus.ser_en    = 1'b1;
        bus.ser_first = (cnt == '0);
        bus.ser_a     = a_q[0];
        bus.ser_b     = b_q[0];
      end
      DONE:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a behavioural serial adder and a result scoreboard.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_ctrl_if #(.N(4)) b4 ();
  serial_add_ctrl_if #(.N(8)) b8 ();

  serial_add_ctrl #(.N(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  serial_add_ctrl #(.N(8)) u_dut8 (.clk(clk), .rst(rst), .bus(b8.slave));

  // Behavioural bit-serial adders, one per instance.
  logic c4, c8, cin4, cin8;
  always_comb begin
    cin4 = b4.ser_first ? 1'b0 : c4;
    b4.ser_sum  = b4.ser_a ^ b4.ser_b ^ cin4;
    b4.ser_cout = (b4.ser_a & b4.ser_b) | (b4.ser_a & cin4) | (b4.ser_b & cin4);
    cin8 = b8.ser_first ? 1'b0 : c8;
    b8.ser_sum  = b8.ser_a ^ b8.ser_b ^ cin8;
    b8.ser_cout = (b8.ser_a & b8.ser_b) | (b8.ser_a & cin8) | (b8.ser_b & cin8);
  end
  always @(posedge clk) begin
    if (b4.ser_en) c4 <= b4.ser_cout;
    if (b8.ser_en) c8 <= b8.ser_cout;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and protocol monitor for the N=4 instance.
  logic [4:0] q4[$];
  logic [4:0] exp4;
  int         acc_cyc = 0;
  int         first_cnt = 0;
  logic       ov_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (b4.in_valid && b4.in_ready) begin
        q4.push_back({1'b0, b4.a} + {1'b0, b4.b});
        acc_cyc   = cyc;
        first_cnt = 0;
      end
      if (b4.ser_first) first_cnt++;
      if (!b4.ser_en) chk("ser_bits_idle", {b4.ser_a, b4.ser_b}, 0);
      if (b4.out_valid && !ov_prev) chk("latency4", cyc - acc_cyc, 5);
      if (b4.out_valid && b4.out_ready) begin
        if (q4.size() == 0) begin
          checks++;
          $error("FAIL unexpected_result: observed sum %0h with no expected entry", b4.sum);
        end else begin
          exp4 = q4.pop_front();
          chk("sum4", b4.sum, exp4[3:0]);
          chk("cout4", b4.cout, exp4[4]);
          chk("ser_first_once", first_cnt, 1);
        end
      end
    end
    ov_prev = b4.out_valid;
  end

  task automatic send4(input logic [3:0] av, input logic [3:0] bv);
    int n;
    b4.a = av;
    b4.b = bv;
    b4.in_valid = 1'b1;
    n = 0;
    while (!b4.in_ready && n < 50) begin tick(); n++; end
    chk("in_ready_wait", b4.in_ready, 1);
    tick();
    b4.in_valid = 1'b0;
  endtask

  task automatic drain4();
    int n;
    n = 0;
    while (q4.size() != 0 && n < 100) begin tick(); n++; end
    chk("drain", q4.size(), 0);
  endtask

  initial begin
    int n;
    int prev_acc;
    logic [3:0] ra, rb;

    b4.in_valid = 1'b0; b4.a = '0; b4.b = '0; b4.out_ready = 1'b1;
    b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.out_ready = 1'b1;
    c4 = 1'b0; c8 = 1'b0;

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", b4.in_ready, 1);
    chk("rst_out_valid", b4.out_valid, 0);
    chk("rst_ser_en", b4.ser_en, 0);
    chk("rst_ser_first", b4.ser_first, 0);
    chk("rst_ser_ab", {b4.ser_a, b4.ser_b}, 0);
    chk("rst_sum", b4.sum, 0);
    chk("rst_cout", b4.cout, 0);

    // 1: basic add
    send4(4'h5, 4'h3);
    drain4();

    // 2: carry out, then carry must clear between words
    send4(4'hF, 4'h1);
    drain4();
    send4(4'hF, 4'hF);
    drain4();

    // 3: backpressure holds the result
    b4.out_ready = 1'b0;
    send4(4'h9, 4'h4);
    n = 0;
    while (!b4.out_valid && n < 50) begin tick(); n++; end
    for (int i = 0; i < 10; i++) begin
      chk("hold_sum", b4.sum, 4'hD);
      chk("hold_valid", b4.out_valid, 1);
      chk("hold_in_ready", b4.in_ready, 0);
      tick();
    end
    b4.out_ready = 1'b1;
    tick();
    chk("release_in_ready", b4.in_ready, 1);
    chk("release_out_valid", b4.out_valid, 0);
    chk("release_drain", q4.size(), 0);

    // 4: reset in the second SHIFT cycle discards the operation
    send4(4'h7, 4'h7);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q4.delete();
    chk("mid_rst_ser_en", b4.ser_en, 0);
    chk("mid_rst_in_ready", b4.in_ready, 1);
    chk("mid_rst_sum", b4.sum, 0);
    chk("mid_rst_cout", b4.cout, 0);
    for (int i = 0; i < 8; i++) begin
      chk("mid_rst_no_valid", b4.out_valid, 0);
      tick();
    end
    send4(4'h2, 4'h2);
    drain4();

    // 5: in_valid held high, 20 random pairs, one op per N+2 clocks
    b4.in_valid = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 20; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      b4.a = ra;
      b4.b = rb;
      n = 0;
      while (!b4.in_ready && n < 50) begin tick(); n++; end
      if (i > 0) chk("throughput", cyc - prev_acc, 6);
      prev_acc = cyc;
      tick();
    end
    b4.in_valid = 1'b0;
    drain4();

    // 6: N=8 instance
    b8.a = 8'hFF;
    b8.b = 8'h01;
    b8.in_valid = 1'b1;
    n = 0;
    while (!b8.in_ready && n < 50) begin tick(); n++; end
    prev_acc = cyc;
    tick();
    b8.in_valid = 1'b0;
    n = 0;
    while (!b8.out_valid && n < 50) begin tick(); n++; end
    chk("latency8", cyc - prev_acc, 9);
    chk("sum8", b8.sum, 8'h00);
    chk("cout8", b8.cout, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
